// File: rtl/ff_pkg.sv
// Shared mode encoding for the multimode flip-flop bank and its cells.
package ff_pkg;

  typedef logic [1:0] ff_mode;

  localparam ff_mode FF_MODE_SR = 2'b00;
  localparam ff_mode FF_MODE_JK = 2'b01;
  localparam ff_mode FF_MODE_D  = 2'b10;
  localparam ff_mode FF_MODE_T  = 2'b11;

  // An SR pair with both inputs high is the illegal combination.
  function automatic logic sr_conflict(input ff_mode m, input logic a, input logic b);
    return (m == FF_MODE_SR) && a && b;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// Single-bit flip-flop that interprets its input pair a/b as SR, JK, D or T
// according to the shared mode; qb is registered alongside q as its complement.
module ff_cell
  import ff_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  ff_mode mode,
  input  logic   a,
  input  logic   b,
  output logic   q,
  output logic   qb
);

  logic q_d;
  logic q_q;
  logic qb_q;

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        FF_MODE_SR: begin
          if (a && !b) begin
            q_d = 1'b1;
          end else if (!a && b) begin
            q_d = 1'b0;
          end else begin
            q_d = q_q;
          end
        end
        FF_MODE_JK: begin
          case ({a, b})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
          endcase
        end
        FF_MODE_D: q_d = a;
        FF_MODE_T: q_d = q_q ^ a;
        default:   q_d = q_q;
      endcase
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q  <= RST_VAL;
      qb_q <= ~RST_VAL;
    end else begin
      q_q  <= q_d;
      qb_q <= ~q_d;
    end
  end

  assign q  = q_q;
  assign qb = qb_q;

endmodule

// File: rtl/multimode_ff_bank.sv
// WIDTH-bit configurable flip-flop bank sharing one SR/JK/D/T mode register.
// Optional sticky sr_err flag is built when FF_BANK_SR_ERR_EN is defined.
module multimode_ff_bank
  import ff_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}},
  parameter logic [1:0]       RST_MODE = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode_wr,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
`ifdef FF_BANK_SR_ERR_EN
  output logic             sr_err,
`endif
  output logic [1:0]       mode
);

  ff_mode mode_d;
  ff_mode mode_q;

  // Cells see mode_q, so a write on the same edge as an update uses the old mode.
  always_comb begin
    if (mode_wr) begin
      mode_d = mode_in;
    end else begin
      mode_d = mode_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= RST_MODE;
    end else begin
      mode_q <= mode_d;
    end
  end

  assign mode = mode_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RST_VAL (RST_VAL[i])
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .mode (mode_q),
      .a    (j[i]),
      .b    (k[i]),
      .q    (q[i]),
      .qb   (qb[i])
    );
  end

`ifdef FF_BANK_SR_ERR_EN
  logic sr_err_d;
  logic sr_err_q;

  always_comb begin
    sr_err_d = sr_err_q;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sr_conflict(mode_q, j[i], k[i])) begin
          sr_err_d = 1'b1;
        end else begin
          sr_err_d = sr_err_d;
        end
      end
    end else begin
      sr_err_d = sr_err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_err_q <= 1'b0;
    end else begin
      sr_err_q <= sr_err_d;
    end
  end

  assign sr_err = sr_err_q;
`endif

endmodule
